// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a register slave.
// The master modport drives addresses, write data and response readies;
// the slave modport is its mirror image.
interface axi_lite_cmd_master_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic [2:0]          AWPROT;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic [2:0]          ARPROT;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input  ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite command master: converts one single-word read or write command
// at a time into an AXI-Lite transaction and returns the result on a
// valid/ready response port. A saturating watchdog flags slaves that stall.
module axi_lite_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 7,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_error,
    output logic                            busy,
    output logic                            timeout_flag,
    axi_lite_cmd_master_if.master           m_axi
);

    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int DW    = C_M_AXI_DATA_WIDTH;
    localparam int SW    = C_M_AXI_DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WRESP = 3'd2,
        RD    = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           r_state, w_state_next;
    logic [AW-1:0]    r_addr, w_addr_next;
    logic [DW-1:0]    r_wdata, w_wdata_next;
    logic [SW-1:0]    r_wstrb, w_wstrb_next;
    logic             r_awvalid, w_awvalid_next;
    logic             r_wvalid, w_wvalid_next;
    logic             r_bready, w_bready_next;
    logic             r_arvalid, w_arvalid_next;
    logic             r_rready, w_rready_next;
    logic             r_rsp_valid, w_rsp_valid_next;
    logic [DW-1:0]    r_rsp_rdata, w_rsp_rdata_next;
    logic [1:0]       r_rsp_resp, w_rsp_resp_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_tmo, w_tmo_next;
    logic             w_accept;
    logic             w_waiting;

    assign cmd_ready = (r_state == IDLE) & ~M_AXI_ARESET;
    assign w_accept  = cmd_valid & cmd_ready;
    // The watchdog only runs while waiting on the slave, not while the
    // response sits unconsumed in DONE.
    assign w_waiting = (r_state == WR) | (r_state == WRESP) |
                       (r_state == RD) | (r_state == RDATA);

    // State register: every piece of state is cleared by reset, which also
    // drops any in-flight VALID/READY and discards a pending response.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_cnt       <= '0;
            r_tmo       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_addr      <= w_addr_next;
            r_wdata     <= w_wdata_next;
            r_wstrb     <= w_wstrb_next;
            r_awvalid   <= w_awvalid_next;
            r_wvalid    <= w_wvalid_next;
            r_bready    <= w_bready_next;
            r_arvalid   <= w_arvalid_next;
            r_rready    <= w_rready_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_rdata <= w_rsp_rdata_next;
            r_rsp_resp  <= w_rsp_resp_next;
            r_cnt       <= w_cnt_next;
            r_tmo       <= w_tmo_next;
        end
    end

    // Next-state logic: transaction sequencing, handshake tracking and the
    // saturating watchdog.
    always_comb begin
        w_state_next     = r_state;
        w_addr_next      = r_addr;
        w_wdata_next     = r_wdata;
        w_wstrb_next     = r_wstrb;
        w_awvalid_next   = r_awvalid;
        w_wvalid_next    = r_wvalid;
        w_bready_next    = r_bready;
        w_arvalid_next   = r_arvalid;
        w_rready_next    = r_rready;
        w_rsp_valid_next = r_rsp_valid;
        w_rsp_rdata_next = r_rsp_rdata;
        w_rsp_resp_next  = r_rsp_resp;
        w_cnt_next       = r_cnt;
        w_tmo_next       = r_tmo;

        // Flag is sticky; the count stops at the limit so it cannot wrap.
        if (w_waiting) begin
            if (r_cnt != TMO_LIMIT) begin
                w_cnt_next = r_cnt + 1'b1;
            end
            if (w_cnt_next == TMO_LIMIT) begin
                w_tmo_next = 1'b1;
            end
        end

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_addr_next  = cmd_addr;
                    w_wdata_next = cmd_wdata;
                    w_wstrb_next = cmd_wstrb;
                    w_cnt_next   = '0;
                    w_tmo_next   = 1'b0;
                    if (cmd_write) begin
                        w_awvalid_next = 1'b1;
                        w_wvalid_next  = 1'b1;
                        w_state_next   = WR;
                    end else begin
                        w_arvalid_next = 1'b1;
                        w_state_next   = RD;
                    end
                end
            end
            WR: begin
                // AW and W complete independently; a dropped VALID marks
                // its channel as done.
                if (m_axi.AWREADY) begin
                    w_awvalid_next = 1'b0;
                end
                if (m_axi.WREADY) begin
                    w_wvalid_next = 1'b0;
                end
                if ((!r_awvalid || m_axi.AWREADY) && (!r_wvalid || m_axi.WREADY)) begin
                    w_bready_next = 1'b1;
                    w_state_next  = WRESP;
                end
            end
            WRESP: begin
                if (m_axi.BVALID) begin
                    w_rsp_resp_next  = m_axi.BRESP;
                    w_rsp_rdata_next = '0;
                    w_rsp_valid_next = 1'b1;
                    w_bready_next    = 1'b0;
                    w_state_next     = DONE;
                end
            end
            RD: begin
                if (m_axi.ARREADY) begin
                    w_arvalid_next = 1'b0;
                    w_rready_next  = 1'b1;
                    w_state_next   = RDATA;
                end
            end
            RDATA: begin
                if (m_axi.RVALID) begin
                    w_rsp_rdata_next = m_axi.RDATA;
                    w_rsp_resp_next  = m_axi.RRESP;
                    w_rsp_valid_next = 1'b1;
                    w_rready_next    = 1'b0;
                    w_state_next     = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    w_rsp_valid_next = 1'b0;
                    w_state_next     = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign m_axi.AWADDR  = r_addr;
    assign m_axi.AWPROT  = 3'b000;
    assign m_axi.AWVALID = r_awvalid;
    assign m_axi.WDATA   = r_wdata;
    assign m_axi.WSTRB   = r_wstrb;
    assign m_axi.WVALID  = r_wvalid;
    assign m_axi.BREADY  = r_bready;
    assign m_axi.ARADDR  = r_addr;
    assign m_axi.ARPROT  = 3'b000;
    assign m_axi.ARVALID = r_arvalid;
    assign m_axi.RREADY  = r_rready;

    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_resp     = r_rsp_resp;
    assign rsp_error    = (r_rsp_resp != 2'b00);
    assign busy         = (r_state != IDLE);
    assign timeout_flag = r_tmo;

endmodule
